uart_stream_fifo: RTL and testbench
===================================

Name: uart_stream_fifo

Overview:
- Byte FIFO with AXI-Stream slave and master ports.
- Instanced between the UART register block and the UART core. TX path: regs → FIFO → core s_axis. RX path: core m_axis → FIFO → regs.
- Decouples CPU bus accesses from bit-rate timing.
- Exports fill level and full/empty flags for status registers and IRQ generation.

Parameters:
DATA_WIDTH, 8, stream data width in bits
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 2**DEPTH_LOG2 = 16 entries); legal range 1..10

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
s_axis_tdata  input  DATA_WIDTH  write data
s_axis_tvalid  input  1  write request
s_axis_tready  output  1  FIFO can accept
m_axis_tdata  output  DATA_WIDTH  head-of-FIFO data
m_axis_tvalid  output  1  head entry valid
m_axis_tready  input  1  consumer accepts head
flush  input  1  synchronous clear, one-cycle pulse
level  output  DATA_WIDTH'(DEPTH_LOG2+1)  current occupancy, 0..2**DEPTH_LOG2 (width DEPTH_LOG2+1)
full  output  1  level == depth
empty  output  1  level == 0
overflow  output  1  sticky overflow flag (optional feature)
drop_cnt  output  8  dropped-write counter (optional feature)

Behaviour:
- Reset (rst=1, asynchronous): wr_ptr=rd_ptr=0; level=0; empty=1; full=0; m_axis_tvalid=0; s_axis_tready=1; overflow=0; drop_cnt=0. Memory contents are not reset. m_axis_tdata is don't-care while tvalid=0.
- Pointers: DEPTH_LOG2+1 bits each, natural binary wrap.
  - full when MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
  - level = wr_ptr - rd_ptr (modulo arithmetic).
- Push: s_axis_tvalid && s_axis_tready at a clk edge → mem[wr_ptr] = tdata; wr_ptr+1.
- Pop: m_axis_tvalid && m_axis_tready at a clk edge → rd_ptr+1.
- Output is first-word-fall-through:
  - m_axis_tdata = mem[rd_ptr[DEPTH_LOG2-1:0]];
  - m_axis_tvalid = !empty.
- Latency: a byte pushed at edge N gives m_axis_tvalid=1 after edge N; a consumer can pop it at edge N+1.
- s_axis_tready = !full. It does not depend on m_axis_tready in the same cycle; there is no combinational path from tready to tready.
- Simultaneous push and pop (not full, not empty): both happen, level unchanged.
- Full: push blocked. A pop in the same cycle still happens, and tready rises the next cycle.
- Empty: tvalid=0, so no pop. A push in the same cycle lands and tvalid rises the next cycle.
- AXI rules:
  - tdata and tvalid on m_axis stay stable while tvalid=1 and tready=0.
  - The upstream side must hold s_axis_tdata while tvalid=1 and tready=0.
- Flush: at the edge where flush=1, both pointers go to 0. Flush overrides any push or pop in the same cycle; that data is discarded. It does not clear overflow or drop_cnt.
- Flags (level, full, empty) are registered/derived from registered pointers and update at the same edge as the pointers.
- Reset asserted mid-transfer: the FIFO empties immediately and asynchronously; in-flight data is lost.

Optional Feature:
Macro: UART_STREAM_FIFO_DROP_EN
- Defined (RX-side use: the UART core must never stall):
  - s_axis_tready is tied to 1.
  - A push while full is discarded without touching pointers or memory. That cycle sets overflow=1 (sticky) and increments drop_cnt, saturating at 255.
  - A push while full with a simultaneous pop is accepted and not dropped.
  - overflow and drop_cnt clear only on rst.
- Undefined: s_axis_tready = !full as above; overflow and drop_cnt are constant 0.

Test Plan:
- Reset, then push 0x41 with m_axis_tready=0 → next cycle tvalid=1, tdata=0x41, level=1, empty=0.
- Push 16 bytes 0x00..0x0F, no pops → full=1, level=16, s_axis_tready=0. Then pop all → bytes return in order 0x00..0x0F; after the last, empty=1, level=0.
- With level=16, assert push 0xAA and pop in the same cycle → pop returns 0x00 and 0xAA is not written (tready was 0). The next-cycle push of 0xAA is accepted; level=16.
- Fill to 5, pulse flush together with push 0x55 → next cycle level=0, empty=1, tvalid=0; 0x55 is absent.
- Continuous push and pop for 40 bytes (pointer wrap twice) with random m_axis_tready stalls → output sequence matches input, tdata stable during stalls, level never above 16.
- With UART_STREAM_FIFO_DROP_EN: fill to 16, push 3 more bytes without pops → tready stays 1, overflow=1, drop_cnt=3, contents unchanged. Assert rst → overflow=0, drop_cnt=0.

Source files
------------

// File: rtl/uart_stream_fifo.sv
// ---------------------------------------------------------------------------
// uart_stream_fifo
//
// Byte FIFO between the UART register block and the UART core, with an
// AXI-Stream slave (write) side and an AXI-Stream master (read) side. The
// read side is first-word-fall-through: the head entry is presented
// combinationally from memory whenever the FIFO is non-empty.
//
// Optional build macro: UART_STREAM_FIFO_DROP_EN
//   Defined   : s_axis_tready is tied high; writes that arrive while the FIFO
//               is full (and nothing pops that cycle) are discarded, setting
//               a sticky overflow flag and a saturating 8-bit drop counter.
//   Undefined : s_axis_tready = !full; overflow and drop_cnt are constant 0.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   s_axis_*        write stream (tdata/tvalid in, tready out)
//   m_axis_*        read stream  (tdata/tvalid out, tready in)
//   flush           synchronous clear pulse; discards contents
//   level           occupancy 0..2**DEPTH_LOG2
//   full, empty     occupancy flags
//   overflow        sticky dropped-write flag (drop build only)
//   drop_cnt        saturating dropped-write count (drop build only)
//
// Handshake: a transfer happens on a rising clk edge where tvalid && tready
// are both high. The producer holds tdata/tvalid stable until accepted;
// m_axis_tdata/tvalid only change at an edge with a pop, push-into-empty,
// flush or reset, so they are stable while tvalid=1 and tready=0. No output
// ready depends combinationally on the opposite side's ready in the default
// build.
// ---------------------------------------------------------------------------
module uart_stream_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic                  flush,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow,
   output logic [7:0]            drop_cnt
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [DEPTH_LOG2:0]   wr_ptr;
   logic [DEPTH_LOG2:0]   rd_ptr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic push;
   logic pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign level = wr_ptr - rd_ptr;

   assign m_axis_tvalid = !empty;
   assign m_axis_tdata  = mem[rd_ptr[DEPTH_LOG2-1:0]];

   assign pop = m_axis_tvalid && m_axis_tready;

`ifdef UART_STREAM_FIFO_DROP_EN
   logic drop;

   // The core must never stall, so the write side always reports ready.
   // A write into a full FIFO still lands when the head pops that same
   // cycle: the slot being written is the one being vacated.
   assign s_axis_tready = 1'b1;
   assign push          = s_axis_tvalid && (!full || pop);
   assign drop          = s_axis_tvalid && full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= 8'd0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end
`else
   assign s_axis_tready = !full;
   assign push          = s_axis_tvalid && s_axis_tready;
   assign overflow      = 1'b0;
   assign drop_cnt      = 8'd0;
`endif

   // Flush wins over any push/pop in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage is not reset; only the pointers define valid contents.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= s_axis_tdata;
      end
   end

endmodule

// File: tb/tb_uart_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_stream_fifo
//
// Directed plus randomised-stall bench for uart_stream_fifo. A queue model
// holds the bytes the FIFO should contain; every cycle the head, flags,
// ready/valid and (drop build) overflow counters are compared against it.
// ---------------------------------------------------------------------------
module tb_uart_stream_fifo;

  localparam int DW    = 8;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
`ifdef UART_STREAM_FIFO_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          flush;
  logic [DL2:0]  level;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  uart_stream_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .flush         (flush),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic          exp_ovf;
  int            exp_drop;
  int            checks;
  int            errors;
  string         phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("level", 32'(level), 32'(exp_q.size()));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("empty", 32'(empty), 32'(exp_q.size() == 0));
    check("m_tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
  endtask

  // ---------------- driver ----------------
  // Called just after a negedge. Drives one cycle of stimulus, checks the
  // pre-edge handshake view, updates the model at the posedge and checks
  // the registered state at the following negedge.
  task automatic cycle(input logic push, input logic [DW-1:0] d,
                       input logic pop, input logic fl);
    logic push_ok;
    logic pop_ok;
    s_axis_tvalid = push;
    s_axis_tdata  = d;
    m_axis_tready = pop;
    flush         = fl;
    #1;
    check("s_tready", 32'(s_axis_tready), 32'(DROP || exp_q.size() < DEPTH));
    check("m_tvalid_pre", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("m_tdata", 32'(m_axis_tdata), 32'(exp_q[0]));
    pop_ok  = pop && (exp_q.size() != 0);
    push_ok = push && ((exp_q.size() < DEPTH) || (DROP && pop_ok));
    if (DROP && push && !push_ok) begin
      exp_ovf = 1'b1;
      if (exp_drop != 255) exp_drop++;
    end
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (pop_ok) void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back(d);
    end
    @(negedge clk);
    check_state();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_drop = 0;
    check_state();
    check("s_tready_rst", 32'(s_axis_tready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sent;
    logic pop_r;
    checks        = 0;
    errors        = 0;
    exp_ovf       = 1'b0;
    exp_drop      = 0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    flush         = 1'b0;
    rst           = 1'b1;

    phase = "reset";
    @(negedge clk);
    do_reset();
    check_state();

    phase = "single";
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);   // held with tready=0: head stays 0x41
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    phase = "fill16";
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    phase = "drain16";
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    phase = "full_pushpop";
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    phase = "flush";
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    phase = "stream";
    sent = 0;
    for (int c = 0; c < 400 && (sent < 40 || exp_q.size() != 0); c++) begin
      pop_r = ($urandom_range(0, 3) != 0);
      if (sent < 40) begin
        if (exp_q.size() < DEPTH || (DROP && pop_r && exp_q.size() != 0)) begin
          cycle(1'b1, 8'h80 + 8'(sent), pop_r, 1'b0);
          sent++;
        end else begin
          cycle(1'b1, 8'h80 + 8'(sent), pop_r, 1'b0);
        end
      end else begin
        cycle(1'b0, 8'h00, pop_r, 1'b0);
      end
    end
    check("stream_done", 32'(sent == 40 && exp_q.size() == 0), 32'd1);

    phase = "async_rst";
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_drop = 0;
    check("level_async", 32'(level), 32'd0);
    check("empty_async", 32'(empty), 32'd1);
    check("tvalid_async", 32'(m_axis_tvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef UART_STREAM_FIFO_DROP_EN
    phase = "drop";
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b1, 1'b0);
    for (int i = 0; i < 255; i++) cycle(1'b1, 8'hEF, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    phase = "drop_rst";
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
